// File: rtl/fp32_pkg.sv
// Shared FP32 types and constants for the step unit datapath.
package fp32_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam int unsigned FP32_BIAS    = 127;

  // Operand A class, resolved in stage 1 and carried to the pack stage.
  typedef enum logic [1:0] {
    KIND_NORM,
    KIND_PASS_B,
    KIND_PASS_A,
    KIND_NAN
  } kind_e;

endpackage

// File: rtl/lzc28.sv
// Combinational 28-bit leading-zero counter; an all-zero input yields 28.
module lzc28 (
  input  logic [27:0] din,
  output logic [4:0]  count
);

  // Scanning upward lets the highest set bit win without a found flag.
  always_comb begin
    count = 5'd28;
    for (int unsigned i = 0; i < 28; i++) begin
      if (din[i]) count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp32_step_unit.sv
// 4-stage elastic FP32 a +/- STEP unit with tag sideband and status flags.
// Define FP32_STEP_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fp32_step_unit
  import fp32_pkg::*;
#(
  parameter logic [31:0] STEP  = 32'h3F800000,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             op_i,
  input  logic [31:0]      a_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [2:0]       flags_o
);

  if (STEP[30:23] == 8'h00 || STEP[30:23] == FP32_EXP_MAX) begin : g_bad_step
    $error("fp32_step_unit: STEP must be finite, normal and nonzero");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("fp32_step_unit: TAG_W must be at least 1");
  end

  logic advance;
  logic v1, v2, v3;

  assign advance = ready_i | ~valid_o;
  assign ready_o = advance;

  // Stage 1: unpack, classify A, order by magnitude.
  fp32_t a_f, b_f, big_f, small_f;
  kind_e a_kind;
  logic  a_big;

  always_comb begin
    a_f    = a_i;
    b_f    = {STEP[31] ^ op_i, STEP[30:0]};
    a_kind = KIND_NORM;
    if (a_f.exp == '0) begin
      a_kind = KIND_PASS_B;
    end else if (a_f.exp == FP32_EXP_MAX) begin
      a_kind = (a_f.man == '0) ? KIND_PASS_A : KIND_NAN;
    end
    a_big   = {a_f.exp, a_f.man} >= {b_f.exp, b_f.man};
    big_f   = a_big ? a_f : b_f;
    small_f = a_big ? b_f : a_f;
  end

  kind_e             s1_kind;
  logic [31:0]       s1_pass;
  logic              s1_sign, s1_sub;
  logic [7:0]        s1_exp, s1_diff;
  logic [23:0]       s1_big_man, s1_small_man;
  logic [TAG_W-1:0]  s1_tag;

  always_ff @(posedge clk_i) begin
    if (advance) begin
      s1_kind      <= a_kind;
      s1_pass      <= (a_kind == KIND_PASS_A) ? a_i : b_f;
      s1_sign      <= big_f.sign;
      s1_exp       <= big_f.exp;
      s1_big_man   <= {1'b1, big_f.man};
      s1_small_man <= {1'b1, small_f.man};
      s1_diff      <= big_f.exp - small_f.exp;
      s1_sub       <= a_f.sign ^ b_f.sign;
      s1_tag       <= tag_i;
    end
  end

  // Stage 2: align Small into {man, guard, round, sticky}.
  logic [26:0] small_ext, shifted, lost_mask, aligned;

  always_comb begin
    small_ext = {s1_small_man, 3'b000};
    shifted   = small_ext >> s1_diff;
    lost_mask = ~({27{1'b1}} << s1_diff);
    if (s1_diff >= 8'd26) begin
      aligned = 27'd1;
    end else begin
      aligned = {shifted[26:1], shifted[0] | (|(small_ext & lost_mask))};
    end
  end

  kind_e             s2_kind;
  logic [31:0]       s2_pass;
  logic              s2_sign, s2_sub;
  logic [7:0]        s2_exp;
  logic [26:0]       s2_big, s2_small;
  logic [TAG_W-1:0]  s2_tag;

  always_ff @(posedge clk_i) begin
    if (advance) begin
      s2_kind  <= s1_kind;
      s2_pass  <= s1_pass;
      s2_sign  <= s1_sign;
      s2_sub   <= s1_sub;
      s2_exp   <= s1_exp;
      s2_big   <= {s1_big_man, 3'b000};
      s2_small <= aligned;
      s2_tag   <= s1_tag;
    end
  end

  // Stage 3: magnitude add/subtract; Big >= Small so the difference is never negative.
  logic [27:0] sum;
  logic [4:0]  sum_lzc;

  assign sum = s2_sub ? ({1'b0, s2_big} - {1'b0, s2_small})
                      : ({1'b0, s2_big} + {1'b0, s2_small});

  lzc28 u_lzc (
    .din   (sum),
    .count (sum_lzc)
  );

  kind_e             s3_kind;
  logic [31:0]       s3_pass;
  logic              s3_sign;
  logic [7:0]        s3_exp;
  logic [27:0]       s3_sum;
  logic [4:0]        s3_lzc;
  logic [TAG_W-1:0]  s3_tag;

  always_ff @(posedge clk_i) begin
    if (advance) begin
      s3_kind <= s2_kind;
      s3_pass <= s2_pass;
      s3_sign <= s2_sign;
      s3_exp  <= s2_exp;
      s3_sum  <= sum;
      s3_lzc  <= sum_lzc;
      s3_tag  <= s2_tag;
    end
  end

  // Stage 4: shifting by the LZC puts the leading 1 at bit 27, so a carry
  // (lzc=0) and a left normalise share exp = big_exp + 1 - lzc.
  logic [27:0]        norm;
  logic               sum_zero;
  logic signed [9:0]  exp_n, exp_r;
  logic [22:0]        frac_r;
  logic [31:0]        res_n;
  logic [2:0]         flags_n;
`ifdef FP32_STEP_RNE_EN
  logic               round_up, rnd_carry;
`endif

  always_comb begin
    norm     = s3_sum << s3_lzc;
    sum_zero = ~|norm;
    exp_n    = $signed({2'b00, s3_exp}) + 10'sd1 - $signed({5'b00000, s3_lzc});
`ifdef FP32_STEP_RNE_EN
    round_up               = norm[3] & (norm[2] | (|norm[1:0]) | norm[4]);
    {rnd_carry, frac_r}    = {1'b0, norm[26:4]} + {23'd0, round_up};
    exp_r                  = exp_n + $signed({9'd0, rnd_carry});
`else
    frac_r = norm[26:4];
    exp_r  = exp_n;
`endif
    res_n   = {s3_sign, exp_r[7:0], frac_r};
    flags_n = 3'b000;
    case (s3_kind)
      KIND_NAN: begin
        res_n   = FP32_QNAN;
        flags_n = 3'b100;
      end
      KIND_PASS_A, KIND_PASS_B: begin
        res_n = s3_pass;
      end
      default: begin
        if (sum_zero) begin
          res_n   = '0;
          flags_n = 3'b001;
        end else if (exp_r <= 10'sd0) begin
          res_n   = {s3_sign, 31'd0};
          flags_n = 3'b001;
        end else if (exp_r >= 10'sd255) begin
          res_n   = {s3_sign, FP32_EXP_MAX, 23'd0};
          flags_n = 3'b010;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
      tag_o    <= '0;
      flags_o  <= '0;
    end else if (advance) begin
      v1      <= valid_i;
      v2      <= v1;
      v3      <= v2;
      valid_o <= v3;
      if (v3) begin
        result_o <= res_n;
        tag_o    <= s3_tag;
        flags_o  <= flags_n;
      end
    end
  end

endmodule
